// File: rtl/serial_frame_tx.sv
// serial_frame_tx: valid/ready parallel-in, serial-out frame transmitter.
// Frame is a start bit (0), DATA_W data bits LSB-first, an optional even-parity
// bit and a stop bit (1). Each bit is held CLKS_PER_BIT cycles and tx_out comes
// straight from a flop.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [CW-1:0]     r_clk_cnt;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_tx_out;
    logic              r_ready;
    logic              r_busy;

    logic              w_bit_end;
    logic [DATA_W-1:0] w_shift_nxt;

    // Last cycle of the current bit, and the shift register after one bit advance
    always_comb begin
        w_bit_end   = (r_clk_cnt == CLK_LAST);
        w_shift_nxt = r_shift >> 1;
    end

    // Frame sequencer: handshake, bit timing and the registered line/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx_out  <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_tx_out  <= 1'b1;
                    if (r_ready && tx_valid) begin
                        // Word and its parity are captured here; later tx_data changes cannot leak in
                        r_shift  <= tx_data;
                        r_par    <= ^tx_data;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_tx_out <= 1'b0;
                        r_state  <= S_START;
                    end else begin
                        r_ready  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_tx_out  <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx_out <= r_par;
                                r_state  <= S_PARITY;
                            end else begin
                                r_tx_out <= 1'b1;
                                r_state  <= S_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= w_shift_nxt;
                            r_tx_out  <= w_shift_nxt[0];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_tx_out  <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        // Ready rises on the last stop edge so a held tx_valid relaunches after one idle cycle
                        r_clk_cnt <= '0;
                        r_busy    <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tx_out <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready = r_ready;
    assign tx_out   = r_tx_out;
    assign busy     = r_busy;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one DUT at 8/4/parity, one at 8/1/no-parity.
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data0, tx_data1;
    logic       tx_valid0, tx_valid1;
    logic       tx_ready0, tx_ready1;
    logic       tx_out0, tx_out1;
    logic       busy0, busy1;

    int n_checks;
    int n_errors;

    // Hand-built frames, bit 0 = start bit. Parity bits: A5->0, 01->1, FF->0, 3C->0, 5A->0.
    localparam logic [10:0] F_A5 = {1'b1, 1'b0, 8'hA5, 1'b0};
    localparam logic [10:0] F_01 = {1'b1, 1'b1, 8'h01, 1'b0};
    localparam logic [10:0] F_FF = {1'b1, 1'b0, 8'hFF, 1'b0};
    localparam logic [10:0] F_3C = {1'b1, 1'b0, 8'h3C, 1'b0};
    localparam logic [10:0] F_5A = {1'b1, 1'b0, 8'h5A, 1'b0};
    localparam logic [9:0]  F_80 = {1'b1, 8'h80, 1'b0};

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data0),
        .tx_valid (tx_valid0),
        .tx_ready (tx_ready0),
        .tx_out   (tx_out0),
        .busy     (busy0)
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data1),
        .tx_valid (tx_valid1),
        .tx_ready (tx_ready1),
        .tx_out   (tx_out1),
        .busy     (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bounded wait, at a negedge, for dut0 to be ready
    task automatic wait_ready0();
        int n;
        n = 0;
        while (tx_ready0 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready0 !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_ready0 timeout: tx_ready=%b required 1", tx_ready0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_out0, busy0, tx_ready0} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset0 out/busy/ready=%b required 100", {tx_out0, busy0, tx_ready0});
        end
        n_checks++;
        if ({tx_out1, busy1, tx_ready1} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset1 out/busy/ready=%b required 100", {tx_out1, busy1, tx_ready1});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (tx_ready0 !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_before_edge got %b required 0", tx_ready0);
        end
        @(negedge clk);
        n_checks++;
        if ({tx_out0, busy0, tx_ready0} !== 3'b101) begin
            n_errors++;
            $display("FAIL ready_after_release out/busy/ready=%b required 101", {tx_out0, busy0, tx_ready0});
        end
    endtask

    task automatic test_single_a5();
        logic [10:0] f;
        int bad;
        f = F_A5;
        bad = 0;
        wait_ready0();
        tx_data0 = 8'hA5;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        for (int k = 0; k < 44; k++) begin
            n_checks++;
            if (tx_out0 !== f[k/4] || busy0 !== 1'b1 || tx_ready0 !== 1'b0) begin
                n_errors++;
                $display("FAIL a5_cycle%0d out/busy/ready=%b%b%b required %b10", k, tx_out0, busy0, tx_ready0, f[k/4]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({tx_out0, busy0, tx_ready0} !== 3'b101) begin
            n_errors++;
            $display("FAIL a5_end out/busy/ready=%b required 101", {tx_out0, busy0, tx_ready0});
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] f1, f2;
        f1 = F_01;
        f2 = F_FF;
        wait_ready0();
        tx_data0 = 8'h01;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_data0 = 8'hFF;
        for (int k = 0; k < 44; k++) begin
            n_checks++;
            if (tx_out0 !== f1[k/4] || busy0 !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_f1_cycle%0d out/busy=%b%b required %b1", k, tx_out0, busy0, f1[k/4]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({tx_out0, busy0, tx_ready0} !== 3'b101) begin
            n_errors++;
            $display("FAIL b2b_idle out/busy/ready=%b required 101", {tx_out0, busy0, tx_ready0});
        end
        @(negedge clk);
        tx_valid0 = 1'b0;
        for (int k = 0; k < 44; k++) begin
            n_checks++;
            if (tx_out0 !== f2[k/4] || busy0 !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_f2_cycle%0d out/busy=%b%b required %b1", k, tx_out0, busy0, f2[k/4]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({tx_out0, busy0, tx_ready0} !== 3'b101) begin
            n_errors++;
            $display("FAIL b2b_end out/busy/ready=%b required 101", {tx_out0, busy0, tx_ready0});
        end
    endtask

    task automatic test_input_ignored();
        logic [10:0] f;
        f = F_3C;
        wait_ready0();
        tx_data0 = 8'h3C;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        for (int k = 0; k < 44; k++) begin
            if (k == 5)  tx_data0 = 8'h00;
            if (k == 10) tx_valid0 = 1'b1;
            if (k == 20) tx_valid0 = 1'b0;
            if (k == 30) tx_valid0 = 1'b1;
            if (k == 38) tx_valid0 = 1'b0;
            #1;
            n_checks++;
            if (tx_out0 !== f[k/4]) begin
                n_errors++;
                $display("FAIL ign_cycle%0d tx_out=%b required %b", k, tx_out0, f[k/4]);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({tx_out0, busy0, tx_ready0} !== 3'b101) begin
                n_errors++;
                $display("FAIL ign_no_relaunch%0d out/busy/ready=%b required 101", k, {tx_out0, busy0, tx_ready0});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] f;
        f = F_5A;
        wait_ready0();
        tx_data0 = 8'hA5;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        repeat (17) @(negedge clk);
        // k=17: inside data bit 3 of A5, which is 0 on the line
        n_checks++;
        if (tx_out0 !== 1'b0 || busy0 !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_bit3 out/busy=%b%b required 01", tx_out0, busy0);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_out0, busy0, tx_ready0} !== 3'b100) begin
            n_errors++;
            $display("FAIL mid_async_reset out/busy/ready=%b required 100", {tx_out0, busy0, tx_ready0});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_ready0 !== 1'b1 || busy0 !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_recover ready/busy=%b%b required 10", tx_ready0, busy0);
        end
        tx_data0 = 8'h5A;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        for (int k = 0; k < 44; k++) begin
            n_checks++;
            if (tx_out0 !== f[k/4] || busy0 !== 1'b1) begin
                n_errors++;
                $display("FAIL 5a_cycle%0d out/busy=%b%b required %b1", k, tx_out0, busy0, f[k/4]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({tx_out0, busy0, tx_ready0} !== 3'b101) begin
            n_errors++;
            $display("FAIL 5a_end out/busy/ready=%b required 101", {tx_out0, busy0, tx_ready0});
        end
    endtask

    task automatic test_fast_no_parity();
        logic [9:0] f;
        int n;
        f = F_80;
        n = 0;
        while (tx_ready1 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (tx_ready1 !== 1'b1) begin
            n_errors++;
            $display("FAIL fast_ready got %b required 1", tx_ready1);
        end
        tx_data1 = 8'h80;
        tx_valid1 = 1'b1;
        @(negedge clk);
        tx_valid1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (tx_out1 !== f[k] || busy1 !== 1'b1) begin
                n_errors++;
                $display("FAIL fast_cycle%0d out/busy=%b%b required %b1", k, tx_out1, busy1, f[k]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({tx_out1, busy1, tx_ready1} !== 3'b101) begin
            n_errors++;
            $display("FAIL fast_end out/busy/ready=%b required 101", {tx_out1, busy1, tx_ready1});
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        tx_data0  = 8'h00;
        tx_valid0 = 1'b0;
        tx_data1  = 8'h00;
        tx_valid1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_input_ignored();
        test_reset_mid_frame();
        test_fast_no_parity();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Serial frame transmitter: accepts one parallel word per valid/ready handshake and shifts it out on a single registered line.
- Frame format: start bit (0), DATA_W data bits LSB-first, optional even-parity bit, stop bit (1).
- Launch-side counterpart of the team's serial capture/receive paths.
- Single clock domain; tx_out is driven directly from a flop so the output path is clean for STA/CTS runs.

Parameters:
DATA_W, 8, payload width in bits (>=1)
CLKS_PER_BIT, 4, clk cycles each serial bit is held (>=1)
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_W  word to send; sampled only on handshake
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line, registered, idles high
busy  output  1  high while a frame is on the line (start through last stop cycle)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, tx_out=1, tx_ready=0, busy=0; shift register and counters cleared.
- First rising clk after rst_n deasserts sets tx_ready=1. tx_ready is a registered output.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- Handshake: accept occurs on a rising edge with tx_valid=1 and tx_ready=1.
  - At that edge: tx_data latched into the shift register; parity = XOR of tx_data latched.
  - Same edge: tx_ready->0, busy->1, tx_out->0, state->START.
  - tx_data/tx_valid are ignored while tx_ready=0; later changes to tx_data do not affect the frame in flight.
- Bit timing: clk_cnt counts 0..CLKS_PER_BIT-1; each bit is held exactly CLKS_PER_BIT cycles. Bit advance happens on the edge where clk_cnt=CLKS_PER_BIT-1.
- DATA: bit_cnt 0..DATA_W-1; tx_out = shift_reg[0]; shift right on each bit advance.
- PARITY: tx_out = latched parity (even parity: total ones across data+parity is even).
- STOP: tx_out=1 for CLKS_PER_BIT cycles.
  - On the last stop-cycle edge: state->IDLE, busy->0, tx_ready->1.
- Frame length: (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles, measured from accept edge to the edge where tx_ready returns high.
- Back-to-back: if tx_valid is held high, the next accept happens on the first edge with tx_ready=1. This gives exactly one cycle of tx_out=1 in IDLE after the stop bit before the next start bit; there are no extra idle cycles.
- CLKS_PER_BIT=1: each bit lasts one cycle; behaviour otherwise identical.
- Reset mid-frame: tx_out goes to 1 immediately (async) and the frame is abandoned. Recovery follows the reset rules above; no partial frame resumes.
- tx_valid deasserting mid-frame: no effect.
- Counter widths: clk_cnt = clog2(CLKS_PER_BIT) bits, min 1; bit_cnt = clog2(DATA_W) bits, min 1. Counters must not wrap within a bit or frame.

Test Plan:
1. Reset, then release rst_n -> tx_out=1, busy=0 throughout reset; tx_ready=0 during reset, 1 one cycle after release.
2. DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1, send 0xA5 -> tx_out per 4-cycle bit: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1; busy high 44 cycles; tx_ready returns at cycle 44.
3. Send 0x01 then 0xFF with tx_valid held high -> parity 1 then 0; exactly one idle-high cycle between frames; second word latched on the first tx_ready=1 edge.
4. Change tx_data to 0x00 and toggle tx_valid mid-frame of 0x3C -> line still shows 0x3C bits (0,0,1,1,1,1,0,0 LSB-first), parity 0; no second frame starts.
5. Assert rst_n=0 during data bit 3 of 0xA5 -> tx_out=1 same cycle (async), busy=0; after release, send 0x5A completes correctly, parity 0.
6. CLKS_PER_BIT=1, PARITY_EN=0, send 0x80 -> 10-cycle frame: 0,0,0,0,0,0,0,0,1,1 (start, 7 zeros, data bit7=1, stop).
